// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential word fetch into a small {instr, pc} buffer with redirect flush.
// Optional FETCH_PERF_EN adds saturating delivered-instruction and decode-bubble counters.
module instr_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_bubbles
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a transfer happens on a cycle where valid && ready at the rising edge;
  // valid never depends on ready, and imem responses arrive in order and cannot be stalled.

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         r_discard;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];

  logic [CW:0]           w_occupancy;
  logic                  w_req_fire;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_dec_valid;
  logic [CW-1:0]         w_out_after_resp;
  logic [ADDR_WIDTH-1:0] w_redirect_target;
  logic                  w_unused_lsbs;

  assign w_occupancy       = {1'b0, r_count} + {1'b0, r_outstanding};
  assign imem_req_valid    = !rst && !redirect_valid && (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr     = r_pc;
  assign w_req_fire        = imem_req_valid && imem_req_ready;
  assign w_push            = imem_resp_valid && (r_discard == '0) && !redirect_valid;
  assign w_dec_valid       = (r_count != '0);
  assign w_pop             = w_dec_valid && dec_ready && !redirect_valid;
  assign w_out_after_resp  = r_outstanding - CW'(imem_resp_valid);
  assign w_redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_lsbs     = ^redirect_pc[1:0];

  assign dec_valid = w_dec_valid;
  assign dec_instr = w_dec_valid ? r_fifo_instr[r_rd_ptr] : '0;
  assign dec_pc    = w_dec_valid ? r_fifo_pc[r_rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory belongs to the old path and must be dropped.
      r_pc          <= w_redirect_target;
      r_resp_pc     <= w_redirect_target;
      r_discard     <= w_out_after_resp;
      r_outstanding <= w_out_after_resp;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      if (w_req_fire) r_pc <= r_pc + ADDR_WIDTH'(4);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + PW'(1);
        r_resp_pc <= r_resp_pc + ADDR_WIDTH'(4);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // The credit check on requests makes a push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_pop && (r_perf_fetched != 32'hFFFF_FFFF)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (dec_ready && !w_dec_valid && !redirect_valid && (r_perf_bubbles != 32'hFFFF_FFFF))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of decode and the immediate sign-extension unit.
- Generates sequential word addresses to instruction memory and buffers returned words with their PCs in a small FIFO.
- Presents {instr, pc} to decode over a valid/ready handshake; decode slices the instr field for immediate extraction.
- Handles branch/jump/call redirects by flushing buffered and in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / instruction memory byte-address width.
- FIFO_DEPTH, 4, entries in the instruction buffer; power of two, >= 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; word-aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  ADDR_WIDTH  byte address of requested word.
- imem_resp_valid  input  1  response word valid; in order, cannot be stalled.
- imem_resp_data  input  DATA_WIDTH  returned instruction word.
- redirect_valid  input  1  taken branch/jump/call from execute.
- redirect_pc  input  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0).
- dec_valid  output  1  FIFO head valid to decode.
- dec_ready  input  1  decode accepts head this cycle.
- dec_instr  output  DATA_WIDTH  instruction at FIFO head.
- dec_pc  output  ADDR_WIDTH  PC of dec_instr.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
- Request issue:
  - imem_req_valid=1 iff !rst && !redirect_valid && (fifo_count + outstanding) < FIFO_DEPTH.
  - imem_req_addr=pc.
  - On handshake (valid&&ready): pc <= pc+4 (wraps modulo 2^ADDR_WIDTH) and outstanding increments.
- Credit rule: the occupancy check above guarantees a response never finds the FIFO full. Overflow is a design error; assert in simulation.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If discard>0, the word is dropped and discard decrements.
  - Otherwise {data, resp_pc} is pushed. resp_pc comes from an internal PC-tracking counter, which equals the address of the oldest outstanding request.
- Output:
  - dec_valid = FIFO non-empty; dec_instr and dec_pc are driven combinationally from the head entry.
  - Pop on dec_valid&&dec_ready.
  - Latency: request accepted at cycle N with memory latency L → earliest dec_valid at N+L+1 (one registered FIFO write).
- Simultaneous push and pop: both happen; count unchanged; full FIFO with pop plus push is legal.
- Redirect (redirect_valid=1, highest priority), in the same cycle:
  - FIFO flushed; pop ignored.
  - Any response arriving that cycle is dropped.
  - No request issued.
  - discard <= outstanding minus any response arriving that cycle.
  - outstanding <= discard's new value.
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - The next cycle issues from the new pc.
- Back-to-back redirects: the last one wins; discard stays consistent with outstanding.
- Reset mid-operation: all state returns to reset values next cycle. The memory side is reset concurrently, so stale responses are not expected.
- outstanding and discard counters are sized to hold FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports perf_fetched [31:0] and perf_bubbles [31:0], reset to 0.
  - perf_fetched increments on each decode pop.
  - perf_bubbles increments each cycle with dec_ready && !dec_valid && !redirect_valid.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Streaming: reset, RESET_PC=0, L=1 memory always ready, dec_ready=1 → dec_pc sequence 0,4,8,12… with matching memory words, first dec_valid 2 cycles after first request.
- Backpressure: dec_ready=0 with FIFO_DEPTH=4 → exactly 4 requests issued (addr 0..12), then imem_req_valid=0. Raise dec_ready → pops in order and requests resume at addr 16.
- Redirect with in-flight: L=3, redirect_pc=0x100 while 3 requests outstanding → 3 responses dropped; first delivered dec_pc=0x100; no stale PCs appear.
- Redirect coincident with response and pop: FIFO holds 2 entries, response arrives and dec_ready=1 in the redirect cycle → nothing delivered; FIFO empty next cycle; next dec_pc = redirect target.
- Misaligned redirect_pc=0x203 → fetch address 0x200. PC wrap: RESET_PC=0xFFFF_FFFC → second request addr 0x0000_0000.
- With FETCH_PERF_EN: 10 instructions delivered plus 3 bubble cycles → perf_fetched=10, perf_bubbles=3. After reset both read 0.
